// File: rtl/mem_read_arbiter_rr_aging_if.sv
// Request/accept bundle between the fetch requesters, the read arbiter and the shared memory port.
interface mem_read_arbiter_rr_aging_if #(
    parameter int unsigned N          = 5,
    parameter int unsigned ADDR_WIDTH = 11
);
    logic [N-1:0]            in_valid;
    logic [N*ADDR_WIDTH-1:0] in_addr;
    logic [N-1:0]            in_ready;
    logic                    out_valid;
    logic [ADDR_WIDTH-1:0]   out_addr;
    logic                    out_ready;

    // Arbiter side: consumes requests, drives the memory request.
    modport slave (
        input  in_valid, in_addr, out_ready,
        output in_ready, out_valid, out_addr
    );

    // Environment side: requesters plus memory.
    modport master (
        output in_valid, in_addr, out_ready,
        input  in_ready, out_valid, out_addr
    );
endinterface

// File: rtl/mem_read_arbiter_rr_aging.sv
// Round-robin instruction-memory read arbiter with grant lock and aging boost for the character port (index N-1).
// Define MEM_ARB_STATS_EN to add the stat_stall / stat_boost counters.
module mem_read_arbiter_rr_aging #(
    parameter int unsigned N          = 5,
    parameter int unsigned ADDR_WIDTH = 11,
    parameter int unsigned AGE_LIMIT  = 8,
    parameter int unsigned AGE_WIDTH  = 8
) (
    input  logic                              clk,
    input  logic                              rst,
    mem_read_arbiter_rr_aging_if.slave        bus,
    output logic                              age_boost
`ifdef MEM_ARB_STATS_EN
    ,
    output logic [31:0]                       stat_stall,
    output logic [15:0]                       stat_boost
`endif
);
    localparam int unsigned           IDX_W   = $clog2(N);
    localparam logic [IDX_W-1:0]      LAST    = IDX_W'(N - 1);
    localparam logic [AGE_WIDTH-1:0]  AGE_LIM = AGE_WIDTH'(AGE_LIMIT);

    typedef enum logic {UNLOCKED, LOCKED} state_t;

    state_t                 state, state_nxt;
    logic [IDX_W-1:0]       rr_ptr;
    logic [IDX_W-1:0]       lock_idx;
    logic                   lock_forced;
    logic [AGE_WIDTH-1:0]   age;

    logic [ADDR_WIDTH-1:0]  addr_arr [N];
    logic [IDX_W-1:0]       rr_grant;
    logic [IDX_W-1:0]       scan_idx;
    logic                   found;
    logic [IDX_W-1:0]       grant;
    logic                   valid_raw;
    logic                   out_valid;
    logic                   handshake;
    logic                   stall;
    logic                   boost;
    logic                   grant_forced;
    logic [N-1:0]           grant_onehot;
    logic [ADDR_WIDTH-1:0]  mem_addr;

    always_comb begin
        for (int unsigned i = 0; i < N; i++) begin
            addr_arr[i] = bus.in_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        end
    end

    always_comb begin
        rr_grant = rr_ptr;
        found    = 1'b0;
        scan_idx = '0;
        for (int unsigned k = 0; k < N; k++) begin
            scan_idx = IDX_W'((32'(rr_ptr) + k) % N);
            if (!found && bus.in_valid[scan_idx]) begin
                found    = 1'b1;
                rr_grant = scan_idx;
            end
        end
    end

    always_comb begin
        grant        = rr_grant;
        valid_raw    = |bus.in_valid;
        grant_forced = 1'b0;
        boost        = (age >= AGE_LIM);
        // A locked grant keeps the "forced" tag it was issued with, so completion under lock is still a forced grant.
        if (state == LOCKED) begin
            grant        = lock_idx;
            valid_raw    = bus.in_valid[lock_idx];
            grant_forced = lock_forced;
        end else if (boost && bus.in_valid[LAST]) begin
            grant        = LAST;
            valid_raw    = 1'b1;
            grant_forced = 1'b1;
        end
        out_valid = rst && valid_raw;
        handshake = out_valid && bus.out_ready;
        stall     = out_valid && !bus.out_ready;
        grant_onehot = '0;
        if (handshake) begin
            grant_onehot[grant] = 1'b1;
        end
        mem_addr  = out_valid ? addr_arr[grant] : '0;
        state_nxt = stall ? LOCKED : UNLOCKED;
    end

    assign bus.out_valid = out_valid;
    assign bus.out_addr  = mem_addr;
    assign bus.in_ready  = grant_onehot;
    assign age_boost     = boost;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= UNLOCKED;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr      <= '0;
            lock_idx    <= '0;
            lock_forced <= 1'b0;
            age         <= '0;
        end else begin
            if (stall) begin
                lock_idx    <= grant;
                lock_forced <= grant_forced;
            end
            if (handshake && !grant_forced) begin
                rr_ptr <= (grant == LAST) ? '0 : grant + IDX_W'(1);
            end
            if (!bus.in_valid[LAST] || (handshake && grant == LAST)) begin
                age <= '0;
            end else if (age != '1) begin
                age <= age + AGE_WIDTH'(1);
            end
        end
    end

`ifdef MEM_ARB_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_stall <= '0;
            stat_boost <= '0;
        end else begin
            if (stall && stat_stall != '1) begin
                stat_stall <= stat_stall + 32'd1;
            end
            if (handshake && grant_forced && stat_boost != '1) begin
                stat_boost <= stat_boost + 16'd1;
            end
        end
    end
`endif

endmodule

// File: doc/mem_read_arbiter_rr_aging.md
Name: mem_read_arbiter_rr_aging

Overview:
- Shares the single instruction-memory read port between N requesters: every engine's fetch port plus the character-fetch port, which is always index N-1.
- Round-robin arbitration with grant lock: once a request is presented, its address and grant stay stable until memory accepts it.
- Aging escalation on the character port, so engine fetch traffic can never starve character fetch.
- Sits between the per-engine memory_read_iface bundles and the shared memory port; read data is broadcast outside this block.

Parameters:
- N, 5, number of requesters (index N-1 = character fetch); N >= 2.
- ADDR_WIDTH, 11, memory address width.
- AGE_LIMIT, 8, wait cycles of request N-1 before forced priority; 1..255.
- AGE_WIDTH, 8, width of the age counter; must hold AGE_LIMIT.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, active-low.
- in_valid  in  N  request valid per requester.
- in_addr  in  N*ADDR_WIDTH  request address; requester i occupies bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- in_ready  out  N  one-hot accept; high only for the requester whose request memory takes this cycle.
- out_valid  out  1  request to memory.
- out_addr  out  ADDR_WIDTH  address to memory.
- out_ready  in  1  memory accepts the request.
- age_boost  out  1  high while the forced-priority condition holds (debug).

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low.
- While rst=0: rr_ptr=0, locked=0, lock_idx=0, age=0. Outputs: out_valid=0, in_ready=0, out_addr=0, age_boost=0. Outputs are combinational from state and inputs, so they read 0 once valids drop.
- Zero latency: grant is combinational; in_ready[g] = out_valid & out_ready & (grant==g). Handshake on out_valid & out_ready.
- Grant selection, two states:
  - UNLOCKED: if age_boost and in_valid[N-1], grant = N-1. Otherwise grant = first i with in_valid[i], scanning rr_ptr, rr_ptr+1, ... mod N. out_valid = |in_valid.
  - LOCKED: grant = lock_idx. out_valid = in_valid[lock_idx]. Other requesters are ignored.
- Transitions:
  - UNLOCKED -> LOCKED when out_valid & !out_ready; lock_idx <= grant.
  - LOCKED -> UNLOCKED on handshake.
  - LOCKED -> UNLOCKED if in_valid[lock_idx] drops (protocol violation tolerated, no grant issued).
  - UNLOCKED stays UNLOCKED on handshake or when idle.
- rr_ptr: on handshake, rr_ptr <= (grant==N-1) ? 0 : grant+1. Unchanged otherwise, including forced grants.
- Age counter:
  - Increments (saturating at 2^AGE_WIDTH-1) each cycle in_valid[N-1]=1 without a handshake for N-1.
  - Clears on handshake with grant N-1.
  - Clears when in_valid[N-1]=0.
  - age_boost = (age >= AGE_LIMIT).
- Boost never breaks a lock: it applies at the next UNLOCKED decision.
- Simultaneous events: a handshake and a new request from the same requester in the same cycle are legal. The next request arbitrates from the updated rr_ptr.
- Single requester: granted every cycle out_ready=1, giving back-to-back throughput of 1 per cycle.
- Reset mid-lock: lock dropped, no in_ready issued; requesters re-present their requests.

Optional Feature:
- Macro: MEM_ARB_STATS_EN.
- Defined:
  - Adds output port stat_stall (32 bits): counts cycles with out_valid & !out_ready.
  - Adds output port stat_boost (16 bits): counts forced grants that complete a handshake.
  - Both counters saturate and reset to 0.
- Undefined: neither port exists and no counter logic is generated.

Test Plan:
- Reset: rst=0 with all in_valid=1 and out_ready=1 -> out_valid=0, in_ready=0; after release, first grant is index 0.
- Round-robin: N=5, all valid, out_ready=1 for 10 cycles -> grant sequence 0,1,2,3,4,0,1,2,3,4; in_ready one-hot each cycle.
- Lock stability: requester 2 granted with out_ready=0 for 3 cycles while requester 1 raises valid -> out_addr stays equal to in_addr[2] and grant stays 2. out_ready=1 -> in_ready[2]=1, next grant 3 if valid else 4, 0, 1 order.
- Aging:
  - Setup: AGE_LIMIT=4; requesters 0..3 always valid; requester 4 valid; out_ready toggles 1,0 each cycle.
  - Check: age_boost rises when age=4; next unlocked decision grants 4; age returns to 0.
- Drop under lock: requester 3 locked, in_valid[3] deasserted -> out_valid follows UNLOCKED arbitration next cycle and no in_ready[3] is issued.
- Stats, with MEM_ARB_STATS_EN: 6 stall cycles plus 1 forced grant -> stat_stall=6, stat_boost=1.
